// File: rtl/muldiv_seq.sv
// Multi-cycle RV64 M-extension unit: shift-add multiply and restoring divide on operand magnitudes.
// Define MULDIV_FASTMUL_EN to turn the MUL* ops into a single combinational multiply.
module muldiv_seq #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] operand1_i,
  input  logic [XLEN-1:0] operand2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic [1:0]      dbg_state
);

  localparam int HALF = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshake: a request is taken when start_i is high in IDLE without flush_i;
  // the requester keeps start_i high until the single-cycle valid_o strobe.
  logic [1:0]        state_q;
  logic [2:0]        op_q;
  logic              word_q;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic              rneg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] prod_q;
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   dvd_q;
  logic [XLEN-1:0]   dsr_q;
  logic [XLEN-1:0]   result_q;

  logic              op_div;
  logic              a_signed;
  logic              b_signed;
  logic              a_neg;
  logic              b_neg;
  logic              div_zero;
  logic              div_ovf;
  logic              fast_mul;
  logic [XLEN-1:0]   a_ext;
  logic [XLEN-1:0]   b_ext;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   min_val;
  logic [CNT_W-1:0]  iter_n;

  // Operand decode; word-mode MULH* variants fall back to signed MUL-W.
  always_comb begin
    op_div = op_i[2];
    if (op_div) begin
      a_signed = ~op_i[0];
      b_signed = ~op_i[0];
    end else begin
      a_signed = word_i | (op_i[1:0] != 2'b11);
      b_signed = word_i | ~op_i[1];
    end
    if (word_i) begin
      a_ext = a_signed ? {{(XLEN-HALF){operand1_i[HALF-1]}}, operand1_i[HALF-1:0]}
                       : {{(XLEN-HALF){1'b0}}, operand1_i[HALF-1:0]};
      b_ext = b_signed ? {{(XLEN-HALF){operand2_i[HALF-1]}}, operand2_i[HALF-1:0]}
                       : {{(XLEN-HALF){1'b0}}, operand2_i[HALF-1:0]};
      min_val = {{(XLEN-HALF+1){1'b1}}, {(HALF-1){1'b0}}};
      iter_n  = CNT_W'(HALF);
    end else begin
      a_ext   = operand1_i;
      b_ext   = operand2_i;
      min_val = {1'b1, {(XLEN-1){1'b0}}};
      iter_n  = CNT_W'(XLEN);
    end
    a_neg    = a_signed & a_ext[XLEN-1];
    b_neg    = b_signed & b_ext[XLEN-1];
    mag_a    = a_neg ? ({XLEN{1'b0}} - a_ext) : a_ext;
    mag_b    = b_neg ? ({XLEN{1'b0}} - b_ext) : b_ext;
    div_zero = op_div & (b_ext == {XLEN{1'b0}});
    div_ovf  = op_div & ~op_i[0] & (a_ext == min_val) & (b_ext == {XLEN{1'b1}});
`ifdef MULDIV_FASTMUL_EN
    fast_mul = ~op_div;
`else
    fast_mul = 1'b0;
`endif
  end

  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     rem_diff;
  logic [2*XLEN-1:0] prod_next;

  always_comb begin
    rem_shift = {rem_q, dvd_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, dsr_q};
    prod_next = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   raw_result;
  logic [XLEN-1:0]   done_result;

  // Sign fix-up happens once, on the way out of the magnitude datapath.
  always_comb begin
    prod_fix = neg_q ? ({(2*XLEN){1'b0}} - prod_q) : prod_q;
    quo_fix  = neg_q ? ({XLEN{1'b0}} - quo_q) : quo_q;
    rem_fix  = rneg_q ? ({XLEN{1'b0}} - rem_q) : rem_q;
    if (op_q[2]) begin
      raw_result = op_q[1] ? rem_fix : quo_fix;
    end else if (word_q || (op_q[1:0] == 2'b00)) begin
      raw_result = prod_fix[XLEN-1:0];
    end else begin
      raw_result = prod_fix[2*XLEN-1:XLEN];
    end
    done_result = word_q ? {{(XLEN-HALF){raw_result[HALF-1]}}, raw_result[HALF-1:0]}
                         : raw_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      word_q   <= 1'b0;
      rd_q     <= 5'd0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      prod_q   <= {(2*XLEN){1'b0}};
      mcand_q  <= {(2*XLEN){1'b0}};
      mplier_q <= {XLEN{1'b0}};
      quo_q    <= {XLEN{1'b0}};
      rem_q    <= {XLEN{1'b0}};
      dvd_q    <= {XLEN{1'b0}};
      dsr_q    <= {XLEN{1'b0}};
      result_q <= {XLEN{1'b0}};
    end else if (flush_i) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_q     <= op_i;
            word_q   <= word_i;
            rd_q     <= rd_i;
            rneg_q   <= a_neg;
            neg_q    <= (div_zero | div_ovf) ? 1'b0 : (a_neg ^ b_neg);
            cnt_q    <= iter_n;
            mcand_q  <= {{XLEN{1'b0}}, mag_a};
            mplier_q <= mag_b;
`ifdef MULDIV_FASTMUL_EN
            prod_q   <= {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`else
            prod_q   <= {(2*XLEN){1'b0}};
`endif
            // Word divides left-align the dividend so the MSB feeds in first.
            dvd_q    <= word_i ? {mag_a[HALF-1:0], {(XLEN-HALF){1'b0}}} : mag_a;
            dsr_q    <= mag_b;
            quo_q    <= div_zero ? {XLEN{1'b1}} : (div_ovf ? a_ext : {XLEN{1'b0}});
            rem_q    <= div_zero ? mag_a : {XLEN{1'b0}};
            state_q  <= (div_zero | div_ovf | fast_mul) ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          if (op_q[2]) begin
            dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
            if (!rem_diff[XLEN]) begin
              rem_q <= rem_diff[XLEN-1:0];
              quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
              rem_q <= rem_shift[XLEN-1:0];
              quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            prod_q   <= prod_next;
            mcand_q  <= {mcand_q[2*XLEN-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[XLEN-1:1]};
          end
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          result_q <= done_result;
          cnt_q    <= {CNT_W{1'b0}};
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // In DONE the fresh result is shown directly; the register holds it afterwards.
  always_comb begin
    busy_o    = (state_q != S_IDLE);
    valid_o   = (state_q == S_DONE) & ~flush_i;
    stall_o   = start_i & ~valid_o;
    result_o  = valid_o ? done_result : result_q;
    rd_o      = rd_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized scoreboard bench for muldiv_seq: driver pushes expected result/rd/latency,
// a negedge monitor pops and compares on every valid_o strobe.
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic        word_i;
  logic [63:0] operand1_i;
  logic [63:0] operand2_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        busy_o;
  logic        stall_o;
  logic        valid_o;
  logic [63:0] result_o;
  logic [4:0]  rd_o;
  logic [1:0]  dbg_state;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [63:0] exp_q[$];
  logic [4:0]  exp_rd_q[$];
  int          exp_lat_q[$];
  int          issue_q[$];

  muldiv_seq #(.XLEN(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .word_i(word_i),
    .operand1_i(operand1_i), .operand2_i(operand2_i), .rd_i(rd_i), .flush_i(flush_i),
    .busy_o(busy_o), .stall_o(stall_o), .valid_o(valid_o), .result_o(result_o),
    .rd_o(rd_o), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic word,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, sb, ua, ub, p;
    logic [31:0]  a32, b32, r32;
    int           sa32, sb32;
    longint       sa64, sb64;
    logic [63:0]  r;
    if (word) begin
      a32 = a[31:0]; b32 = b[31:0];
      sa32 = a32; sb32 = b32;
      case (op)
        3'd4: r32 = (b32 == 0) ? 32'hFFFF_FFFF :
                    (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) ? a32 : 32'(sa32 / sb32);
        3'd5: r32 = (b32 == 0) ? 32'hFFFF_FFFF : a32 / b32;
        3'd6: r32 = (b32 == 0) ? a32 :
                    (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa32 % sb32);
        3'd7: r32 = (b32 == 0) ? a32 : a32 % b32;
        default: r32 = a32 * b32;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      sa = {{64{a[63]}}, a}; sb = {{64{b[63]}}, b};
      ua = {64'd0, a};       ub = {64'd0, b};
      sa64 = a; sb64 = b;
      case (op)
        3'd0: r = a * b;
        3'd1: begin p = sa * sb; r = p[127:64]; end
        3'd2: begin p = sa * ub; r = p[127:64]; end
        3'd3: begin p = ua * ub; r = p[127:64]; end
        3'd4: r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF :
                  (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) ? a : 64'(sa64 / sb64);
        3'd5: r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
        3'd6: r = (b == 0) ? a :
                  (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) ? 64'd0 : 64'(sa64 % sb64);
        default: r = (b == 0) ? a : a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int lat_model(input logic [2:0] op, input logic word,
                                   input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    zero = word ? (b[31:0] == 0) : (b == 0);
    ovf  = word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
    if (op[2] && (zero || (!op[0] && ovf))) return 1;
`ifdef MULDIV_FASTMUL_EN
    if (!op[2]) return 1;
`endif
    return (word ? 32 : 64) + 1;
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [2:0] op, input logic word, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input bit perturb);
    bit got;
    got = 0;
    @(negedge clk);
    start_i = 1'b1; op_i = op; word_i = word; operand1_i = a; operand2_i = b; rd_i = rd;
    exp_q.push_back(ref_model(op, word, a, b));
    exp_rd_q.push_back(rd);
    exp_lat_q.push_back(lat_model(op, word, a, b));
    issue_q.push_back(cyc);
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (i == 0) check("busy_after_accept", 64'(busy_o), 64'd1);
      if (perturb && i == 3) begin
        operand1_i = {$urandom, $urandom};
        operand2_i = {$urandom, $urandom};
        rd_i = 5'(rd + 1);
      end
      if (valid_o) begin
        got = 1;
        check("stall_at_valid", 64'(stall_o), 64'd0);
      end
    end
    start_i = 1'b0;
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL valid_timeout: got no valid_o, want valid_o for op %0d", op);
      void'(exp_q.pop_back()); void'(exp_rd_q.pop_back());
      void'(exp_lat_q.pop_back()); void'(issue_q.pop_back());
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
    end
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && valid_o) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_valid: got result %0h, want no valid_o", result_o);
      end else begin
        check("result", result_o, exp_q.pop_front());
        check("rd", 64'(rd_o), 64'(exp_rd_q.pop_front()));
        check("latency", 64'(cyc - issue_q.pop_front()), 64'(exp_lat_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start_i = 1'b0; op_i = 3'd0; word_i = 1'b0;
    operand1_i = 64'd0; operand2_i = 64'd0; rd_i = 5'd0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_valid", 64'(valid_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_rd", 64'(rd_o), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;

    run_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 0);
    run_op(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 0);
    run_op(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 0);
    run_op(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, 0);
    run_op(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, 0);
    run_op(3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 5'd10, 0);
    run_op(3'd4, 1'b0, 64'd12345, 64'd0, 5'd11, 0);
    run_op(3'd7, 1'b0, 64'd12345, 64'd0, 5'd12, 0);
    run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 0);
    run_op(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 5'd14, 1);

    // Flush mid-divide: dropped, no strobe, unit idle afterwards.
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd4; word_i = 1'b0; operand1_i = 64'd1000; operand2_i = 64'd3; rd_i = 5'd20;
    repeat (10) @(negedge clk);
    start_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("busy_after_flush", 64'(busy_o), 64'd0);
    // Start together with flush in IDLE is not taken.
    start_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    check("flush_blocks_start", 64'(busy_o), 64'd0);
    run_op(3'd5, 1'b0, 64'd100, 64'd7, 5'd21, 0);

    // Reset in the middle of MULHSU clears everything at once.
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd2; word_i = 1'b0; operand1_i = 64'hFFFF_0000_1234_5678; operand2_i = 64'd99; rd_i = 5'd22;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midop_rst_busy", 64'(busy_o), 64'd0);
    check("midop_rst_valid", 64'(valid_o), 64'd0);
    check("midop_rst_result", result_o, 64'd0);
    check("midop_rst_rd", 64'(rd_o), 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 40; n++) begin
      run_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pick_operand(), pick_operand(),
             5'($urandom_range(0, 31)), bit'($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
